// File: rtl/alu_chain_pkg.sv
// Shared opcodes, FSM encoding and helpers for the multi-precision ALU sequencer.
package alu_chain_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_ADC = 3'b001;
    localparam logic [2:0] OP_SBC = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_NOT = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // True for opcodes whose final carry/borrow is reported on out_co.
    function automatic logic is_carry_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_ADC) || (op == OP_SBC);
    endfunction

endpackage

// File: rtl/alu_chain_ctrl_if.sv
// Request/response handshake bundle of the multi-precision ALU sequencer.
interface alu_chain_ctrl_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned WORDS = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic [2:0]               in_op;
    logic [WIDTH*WORDS-1:0]   in_a;
    logic [WIDTH*WORDS-1:0]   in_b;
    logic                     in_ci;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH*WORDS-1:0]   out_result;
    logic                     out_co;
    logic                     busy;

    modport master (
        output in_valid, in_op, in_a, in_b, in_ci, out_ready,
        input  in_ready, out_valid, out_result, out_co, busy
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_ci, out_ready,
        output in_ready, out_valid, out_result, out_co, busy
    );
endinterface

// File: rtl/alu_112.sv
// Combinational single-slice ALU; co is carry for add, borrow for subtract.
module alu_112
    import alu_chain_pkg::*;
#(
    parameter int unsigned WITDH = 32
) (
    input  logic [2:0]       op_i,
    input  logic [WITDH-1:0] a_i,
    input  logic [WITDH-1:0] b_i,
    input  logic             ci_i,
    output logic [WITDH-1:0] result_o,
    output logic             co_o
);

    logic [WITDH:0] ext;

    // Extended-width arithmetic puts carry/borrow in the top bit.
    always_comb begin
        ext      = '0;
        result_o = '0;
        co_o     = 1'b0;
        case (op_i)
            OP_ADD: begin
                ext      = {1'b0, a_i} + {1'b0, b_i};
                result_o = ext[WITDH-1:0];
                co_o     = ext[WITDH];
            end
            OP_ADC: begin
                ext      = {1'b0, a_i} + {1'b0, b_i} + {{WITDH{1'b0}}, ci_i};
                result_o = ext[WITDH-1:0];
                co_o     = ext[WITDH];
            end
            OP_SBC: begin
                ext      = {1'b0, a_i} - {1'b0, b_i} - {{WITDH{1'b0}}, ci_i};
                result_o = ext[WITDH-1:0];
                co_o     = ext[WITDH];
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_NOT:  result_o = ~a_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_chain_ctrl.sv
// Sequences one wide operation through a single slice ALU, LSB slice first.
module alu_chain_ctrl
    import alu_chain_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned WORDS = 2
) (
    input  logic              clk,
    input  logic              rst,
    alu_chain_ctrl_if.slave   bus
);

    localparam int unsigned W_TOT = WIDTH * WORDS;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [2:0]         op_q;
    logic [W_TOT-1:0]   a_q;
    logic [W_TOT-1:0]   b_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic [W_TOT-1:0]   out_result_q;
    logic [W_TOT-1:0]   out_result_d;
    logic               out_co_q;

    logic [WIDTH-1:0]   a_slice_c;
    logic [WIDTH-1:0]   b_slice_c;
    logic [WIDTH-1:0]   res_slice_c;
    logic [2:0]         slice_op_c;
    logic               co_slice_c;
    logic               accept_c;
    logic               last_c;

    assign accept_c = bus.in_valid && in_ready_q;
    assign last_c   = (idx_q == IDX_W'(WORDS - 1));

    // Select the current operand slices; later add slices chain the carry via ADC.
    always_comb begin
        a_slice_c  = '0;
        b_slice_c  = '0;
        slice_op_c = op_q;
        for (int unsigned k = 0; k < WORDS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                a_slice_c = a_q[k*WIDTH +: WIDTH];
                b_slice_c = b_q[k*WIDTH +: WIDTH];
            end
        end
        if ((idx_q != '0) && (op_q == OP_ADD)) begin
            slice_op_c = OP_ADC;
        end
    end

    alu_112 #(
        .WITDH (WIDTH)
    ) u_slice_alu (
        .op_i     (slice_op_c),
        .a_i      (a_slice_c),
        .b_i      (b_slice_c),
        .ci_i     (carry_q),
        .result_o (res_slice_c),
        .co_o     (co_slice_c)
    );

    // Merge the freshly computed slice into the result word.
    always_comb begin
        out_result_d = out_result_q;
        for (int unsigned k = 0; k < WORDS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                out_result_d[k*WIDTH +: WIDTH] = res_slice_c;
            end
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state_q)
            S_IDLE:  if (accept_c)      state_d = S_RUN;
            S_RUN:   if (last_c)        state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // FSM state and handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Request latch, slice index, carry chain and result accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q         <= OP_ADD;
            a_q          <= '0;
            b_q          <= '0;
            carry_q      <= 1'b0;
            idx_q        <= '0;
            out_result_q <= '0;
            out_co_q     <= 1'b0;
        end else if (accept_c) begin
            op_q    <= bus.in_op;
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            carry_q <= bus.in_ci;
            idx_q   <= '0;
        end else if (state_q == S_RUN) begin
            out_result_q <= out_result_d;
            carry_q      <= co_slice_c;
            if (last_c) begin
                idx_q    <= '0;
                out_co_q <= is_carry_op(op_q) ? co_slice_c : 1'b0;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.out_result = out_result_q;
    assign bus.out_co     = out_co_q;

endmodule

// File: tb/tb_alu_chain_ctrl.sv
// Scoreboard bench for alu_chain_ctrl with WIDTH=32, WORDS=2.
module tb_alu_chain_ctrl;

    typedef struct packed {
        logic [63:0] res;
        logic        co;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    exp_t sb_q[$];

    alu_chain_ctrl_if #(.WIDTH(32), .WORDS(2)) bus();

    alu_chain_ctrl #(.WIDTH(32), .WORDS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            exp_t e;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result %h co %b expected none",
                         bus.out_result, bus.out_co);
            end else begin
                e = sb_q.pop_front();
                chk("out_result", bus.out_result, e.res);
                chk("out_co", 64'(bus.out_co), 64'(e.co));
            end
        end
    end

    // Issue one request; returns #1 after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic ci, input logic [63:0] er, input logic eco, input bit push);
        int n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        end
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_ci    = ci;
        if (push) sb_q.push_back('{res: er, co: eco});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = ~a;
        bus.in_b     = ~b;
        bus.in_ci    = ~ci;
        bus.in_op    = 3'b111;
    endtask

    localparam logic [63:0] LA = 64'h0F0F_0000_FFFF_1234;
    localparam logic [63:0] LB = 64'h00FF_FFFF_0000_4321;

    initial begin
        int n;
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'b000;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_ci     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_out_result", bus.out_result, 64'd0);
        chk("rst_out_co", 64'(bus.out_co), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Add with carry across slice boundary, plus latency check
        issue(3'b000, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1);
        @(negedge clk);
        chk("lat_valid_T", 64'(bus.out_valid), 64'd0);
        chk("lat_busy_T", 64'(bus.busy), 64'd1);
        @(negedge clk);
        chk("lat_valid_T1", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("lat_valid_T2", 64'(bus.out_valid), 64'd1);

        // Op 000 ignores ci
        issue(3'b000, 64'd1, 64'd2, 1'b1, 64'd3, 1'b0, 1);
        // Add with carry-in and overflow
        issue(3'b001, 64'd456, 64'd234, 1'b1, 64'd691, 1'b0, 1);
        issue(3'b001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1);
        // Subtract with borrow
        issue(3'b010, 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1);
        issue(3'b010, 64'd245, 64'd678, 1'b1, 64'hFFFF_FFFF_FFFF_FE4E, 1'b1, 1);
        issue(3'b010, 64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1);
        // Logic ops and reserved
        issue(3'b011, LA, LB, 1'b1, 64'h000F_0000_0000_0220, 1'b0, 1);
        issue(3'b100, LA, LB, 1'b1, 64'h0FFF_FFFF_FFFF_5335, 1'b0, 1);
        issue(3'b101, LA, LB, 1'b0, 64'h0FF0_FFFF_FFFF_5115, 1'b0, 1);
        issue(3'b110, LA, LB, 1'b0, 64'hF0F0_FFFF_0000_EDCB, 1'b0, 1);
        issue(3'b111, LA, LB, 1'b1, 64'd0, 1'b0, 1);

        // Backpressure: hold out_ready low for 5 cycles
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        issue(3'b001, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b1,
              64'h0000_0001_0000_0001, 1'b0, 1);
        n = 0;
        @(negedge clk);
        while (bus.out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("bp_valid_seen", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_out_result", bus.out_result, 64'h0000_0001_0000_0001);
            chk("bp_out_co", 64'(bus.out_co), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(bus.out_valid), 64'd0);

        // Reset one edge after accept discards the operation
        issue(3'b000, 64'd10, 64'd20, 1'b0, 64'd30, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("mid_rst_out_result", bus.out_result, 64'd0);
        chk("mid_rst_out_co", 64'(bus.out_co), 64'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_no_valid", 64'(bus.out_valid), 64'd0);
        issue(3'b010, 64'h0000_0005_0000_0000, 64'h0000_0000_0000_0001, 1'b1,
              64'h0000_0004_FFFF_FFFE, 1'b0, 1);

        // Drain scoreboard
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        if (sb_q.size() != 0) begin
            chk("drain_timeout", 64'(sb_q.size()), 64'd0);
        end
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
